// File: rtl/uart_stream_arbiter.sv
// ---------------------------------------------------------------------------
// uart_stream_arbiter
//
// Shares the single byte-wide AXI-stream input of the UART packetizer between
// up to four byte-stream sources. One source is granted per packet, in
// round-robin order. The grant is held until that source's tlast beat is
// accepted, or until MAX_PKT_LEN data beats have been accepted. An optional
// source-ID header byte is sent in front of every packet.
//
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   s_axis_tdata    NUM_SRC source bytes, source i in bits [8i+7:8i]
//   s_axis_tvalid   per-source valid
//   s_axis_tlast    per-source end-of-packet
//   s_axis_tready   per-source ready, at most one bit high
//   m_axis_tdata    byte to the packetizer
//   m_axis_tvalid   byte valid to the packetizer
//   m_axis_tready   packetizer ready
//   grant_id        index of the current or most recent granted source
//   busy            high while a packet is in progress (HEADER or DATA)
//   len_err         one-cycle pulse after a packet is cut at MAX_PKT_LEN
// ---------------------------------------------------------------------------
module uart_stream_arbiter #(
    parameter int         NUM_SRC     = 4,
    parameter bit         HEADER_EN   = 1'b1,
    parameter logic [3:0] HEADER_TAG  = 4'hA,
    parameter int         MAX_PKT_LEN = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_SRC*8-1:0] s_axis_tdata,
    input  logic [NUM_SRC-1:0]   s_axis_tvalid,
    input  logic [NUM_SRC-1:0]   s_axis_tlast,
    output logic [NUM_SRC-1:0]   s_axis_tready,
    output logic [7:0]           m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic [1:0]           grant_id,
    output logic                 busy,
    output logic                 len_err
);

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        DATA
    } state_t;

    localparam logic [7:0] MaxLen  = 8'(MAX_PKT_LEN);
    localparam logic [1:0] LastSrc = 2'(NUM_SRC - 1);

    state_t     state_q, state_d;
    logic [1:0] grantId_q, grantId_d;
    logic [1:0] rrPtr_q, rrPtr_d;
    logic [7:0] beatCnt_q, beatCnt_d;
    logic       lenErr_q, lenErr_d;

    // Source buses widened to the four-source maximum so the 2-bit grant
    // index selects cleanly for any legal NUM_SRC.
    logic [31:0] dataPad;
    logic [3:0]  validPad;
    logic [3:0]  lastPad;
    logic [3:0]  readyPad;

    assign dataPad  = 32'(s_axis_tdata);
    assign validPad = 4'(s_axis_tvalid);
    assign lastPad  = 4'(s_axis_tlast);

    // Round-robin search: the first requester found starting one past the
    // last granted source wins, so a source that just finished goes last.
    logic       pickFound;
    logic [1:0] pickIdx;
    logic [1:0] candIdx;

    always_comb begin
        pickFound = 1'b0;
        pickIdx   = '0;
        candIdx   = '0;
        for (int k = 1; k <= 4; k++) begin
            if (k <= NUM_SRC && !pickFound) begin
                candIdx = 2'((int'(rrPtr_q) + k) % NUM_SRC);
                if (validPad[candIdx]) begin
                    pickFound = 1'b1;
                    pickIdx   = candIdx;
                end
            end
        end
    end

    // Next-state and output decode. DATA is a pure combinational
    // passthrough of the granted source, so there is no buffering here.
    logic beatXfer;
    logic beatLast;
    logic lenHit;

    always_comb begin
        state_d       = state_q;
        grantId_d     = grantId_q;
        rrPtr_d       = rrPtr_q;
        beatCnt_d     = beatCnt_q;
        lenErr_d      = 1'b0;
        readyPad      = '0;
        m_axis_tdata  = '0;
        m_axis_tvalid = 1'b0;
        beatXfer      = validPad[grantId_q] && m_axis_tready;
        beatLast      = lastPad[grantId_q];
        lenHit        = (beatCnt_q + 8'd1) == MaxLen;

        unique case (state_q)
            IDLE: begin
                if (pickFound) begin
                    grantId_d = pickIdx;
                    rrPtr_d   = pickIdx;
                    beatCnt_d = '0;
                    state_d   = HEADER_EN ? HEADER : DATA;
                end
            end

            // The header goes out regardless of the source's valid.
            HEADER: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = {HEADER_TAG, 2'b00, grantId_q};
                if (m_axis_tready) begin
                    state_d = DATA;
                end
            end

            // tlast on the beat that reaches the limit is a normal end;
            // only an unfinished packet is cut and flagged.
            DATA: begin
                m_axis_tdata           = dataPad[{grantId_q, 3'b000} +: 8];
                m_axis_tvalid          = validPad[grantId_q];
                readyPad[grantId_q]    = m_axis_tready;
                if (beatXfer) begin
                    beatCnt_d = beatCnt_q + 8'd1;
                    if (beatLast) begin
                        state_d = IDLE;
                    end else if (lenHit) begin
                        state_d  = IDLE;
                        lenErr_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers. Reset aborts any packet in flight immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            grantId_q <= '0;
            rrPtr_q   <= LastSrc;
            beatCnt_q <= '0;
            lenErr_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            grantId_q <= grantId_d;
            rrPtr_q   <= rrPtr_d;
            beatCnt_q <= beatCnt_d;
            lenErr_q  <= lenErr_d;
        end
    end

    assign s_axis_tready = readyPad[NUM_SRC-1:0];
    assign grant_id      = grantId_q;
    assign busy          = (state_q != IDLE);
    assign len_err       = lenErr_q;

endmodule

// File: tb/tb_uart_stream_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_stream_arbiter
//
// Directed bench for uart_stream_arbiter, built with MAX_PKT_LEN=4 so the
// truncation path is reachable with short packets. Sources are modelled as
// per-source byte lists that present their head byte and advance on accept.
// ---------------------------------------------------------------------------
module tb_uart_stream_arbiter;

    logic        clk;
    logic        rst;
    logic [31:0] sTdata;
    logic [3:0]  sTvalid;
    logic [3:0]  sTlast;
    logic [3:0]  sTready;
    logic [7:0]  mTdata;
    logic        mTvalid;
    logic        mTready;
    logic [1:0]  grantId;
    logic        busy;
    logic        lenErr;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    logic [8:0] srcMem[4][16];
    int         srcLen[4];
    int         srcPos[4];

    logic [7:0] outMem[256];
    int         outCnt     = 0;
    int         lenErrCnt  = 0;
    int         lenErrAt   = 0;
    int         busyCnt    = 0;
    logic [7:0] expQ[$];

    uart_stream_arbiter #(
        .NUM_SRC    (4),
        .HEADER_EN  (1'b1),
        .HEADER_TAG (4'hA),
        .MAX_PKT_LEN(4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_axis_tdata (sTdata),
        .s_axis_tvalid(sTvalid),
        .s_axis_tlast (sTlast),
        .s_axis_tready(sTready),
        .m_axis_tdata (mTdata),
        .m_axis_tvalid(mTvalid),
        .m_axis_tready(mTready),
        .grant_id     (grantId),
        .busy         (busy),
        .len_err      (lenErr)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor on the falling edge: records every byte the packetizer
    // accepts, len_err pulses and busy cycles.
    always @(negedge clk) begin
        if (!rst) begin
            if (mTvalid && mTready) begin
                outMem[outCnt[7:0]] <= mTdata;
                outCnt              <= outCnt + 1;
            end
            if (lenErr) begin
                lenErrCnt <= lenErrCnt + 1;
                lenErrAt  <= outCnt;
            end
            if (busy) begin
                busyCnt <= busyCnt + 1;
            end
        end
    end

    // Hard stop in case something wedges outside a bounded wait.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount = checkCount + 1;
        assert (observed === expected) passCount = passCount + 1;
        else begin
            failCount = failCount + 1;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int pendingCount();
        int n = 0;
        for (int s = 0; s < 4; s++) n += srcLen[s] - srcPos[s];
        return n;
    endfunction

    // Presents each source's head byte, or idles it when its list is empty.
    task automatic applyStimulus();
        for (int s = 0; s < 4; s++) begin
            if (srcPos[s] < srcLen[s]) begin
                sTvalid[s]       = 1'b1;
                sTdata[s*8 +: 8] = srcMem[s][srcPos[s]][7:0];
                sTlast[s]        = srcMem[s][srcPos[s]][8];
            end else begin
                sTvalid[s]       = 1'b0;
                sTdata[s*8 +: 8] = 8'h00;
                sTlast[s]        = 1'b0;
            end
        end
    endtask

    task automatic clearSources();
        for (int s = 0; s < 4; s++) begin
            srcLen[s] = 0;
            srcPos[s] = 0;
        end
        applyStimulus();
    endtask

    // Fills a source with n bytes counting up from first, tlast every
    // pktLen bytes and on the final byte.
    task automatic loadSrc(input int s, input int n, input logic [7:0] first, input int pktLen);
        for (int k = 0; k < n; k++) begin
            srcMem[s][k] = {((k % pktLen == pktLen - 1) || (k == n - 1)) ? 1'b1 : 1'b0, 8'(int'(first) + k)};
        end
        srcLen[s] = n;
        srcPos[s] = 0;
    endtask

    task automatic srcCycle();
        logic [3:0] xfer;
        applyStimulus();
        @(negedge clk);
        xfer = sTvalid & sTready;
        step();
        for (int s = 0; s < 4; s++) if (xfer[s]) srcPos[s] = srcPos[s] + 1;
    endtask

    task automatic runSources(input string tag, input int maxCycles, output int cycles);
        cycles = 0;
        while (pendingCount() > 0 && cycles < maxCycles) begin
            srcCycle();
            cycles = cycles + 1;
        end
        applyStimulus();
        checkOutput({tag, "_drained"}, pendingCount(), 0);
    endtask

    task automatic checkStream(input string tag, input int base);
        checkOutput({tag, "_count"}, outCnt - base, expQ.size());
        for (int i = 0; i < expQ.size(); i++) begin
            checkOutput($sformatf("%s_byte%0d", tag, i), outMem[(base + i) % 256], expQ[i]);
        end
    endtask

    task automatic applyReset(input string tag);
        rst     = 1'b1;
        mTready = 1'b1;
        clearSources();
        step();
        step();
        checkOutput({tag, "_rst_outs"}, {sTready, mTvalid, mTdata, grantId, busy, lenErr}, 32'h0);
        rst = 1'b0;
    endtask

    initial begin
        int base;
        int errBase;
        int busyBase;
        int cycles;

        rst     = 1'b1;
        mTready = 1'b1;
        sTdata  = '0;
        sTvalid = '0;
        sTlast  = '0;
        clearSources();

        // Single source: header 0xA1 then 0x55, busy for two cycles.
        applyReset("single");
        base     = outCnt;
        busyBase = busyCnt;
        loadSrc(1, 1, 8'h55, 1);
        runSources("single", 20, cycles);
        expQ = '{8'hA1, 8'h55};
        checkStream("single", base);
        checkOutput("single_cycles", cycles, 3);
        checkOutput("single_busy", busyCnt - busyBase, 2);
        checkOutput("single_grant", grantId, 2'd1);
        checkOutput("single_idle", {busy, mTvalid}, 2'b00);

        // Four simultaneous 3-byte packets: grants 0,1,2,3, one IDLE each.
        applyReset("all4");
        base = outCnt;
        for (int s = 0; s < 4; s++) loadSrc(s, 3, 8'(16 * s + 1), 3);
        runSources("all4", 60, cycles);
        expQ = '{8'hA0, 8'h01, 8'h02, 8'h03, 8'hA1, 8'h11, 8'h12, 8'h13,
                 8'hA2, 8'h21, 8'h22, 8'h23, 8'hA3, 8'h31, 8'h32, 8'h33};
        checkStream("all4", base);
        checkOutput("all4_cycles", cycles, 20);
        checkOutput("all4_grant", grantId, 2'd3);

        // Backpressure: 20 stalled cycles on src2 byte 0xF0.
        applyReset("bp");
        base    = outCnt;
        sTvalid = 4'b0100;
        sTdata  = 32'h00F0_0000;
        sTlast  = 4'b0000;
        #1;
        checkOutput("bp_idle", {mTvalid, sTready}, 5'b0_0000);
        step();
        checkOutput("bp_header", {mTvalid, sTready, mTdata}, {1'b1, 4'b0000, 8'hA2});
        step();
        mTready = 1'b0;
        #1;
        for (int i = 0; i < 20; i++) begin
            checkOutput($sformatf("bp_hold%0d", i), {mTvalid, sTready, mTdata}, {1'b1, 4'b0000, 8'hF0});
            step();
        end
        mTready = 1'b1;
        #1;
        checkOutput("bp_release", {mTvalid, sTready, mTdata}, {1'b1, 4'b0100, 8'hF0});
        step();
        sTdata = 32'h00F1_0000;
        sTlast = 4'b0100;
        #1;
        checkOutput("bp_second", mTdata, 8'hF1);
        step();
        sTvalid = 4'b0000;
        sTlast  = 4'b0000;
        #1;
        checkOutput("bp_done", {busy, mTvalid}, 2'b00);
        expQ = '{8'hA2, 8'hF0, 8'hF1};
        checkStream("bp", base);

        // Length limit of 4: 6 bytes split into two packets, one len_err.
        applyReset("len");
        base    = outCnt;
        errBase = lenErrCnt;
        loadSrc(0, 6, 8'h01, 6);
        runSources("len", 40, cycles);
        expQ = '{8'hA0, 8'h01, 8'h02, 8'h03, 8'h04, 8'hA0, 8'h05, 8'h06};
        checkStream("len", base);
        checkOutput("len_cycles", cycles, 10);
        checkOutput("len_errcnt", lenErrCnt - errBase, 1);
        checkOutput("len_errpos", lenErrAt - base, 5);

        // tlast on exactly the fourth beat ends normally with no len_err.
        base    = outCnt;
        errBase = lenErrCnt;
        loadSrc(1, 4, 8'h41, 4);
        runSources("exact", 40, cycles);
        expQ = '{8'hA1, 8'h41, 8'h42, 8'h43, 8'h44};
        checkStream("exact", base);
        checkOutput("exact_cycles", cycles, 6);
        step();
        checkOutput("exact_errcnt", lenErrCnt - errBase, 0);

        // Rotation between src0 and src2 continuously requesting.
        applyReset("rot");
        base = outCnt;
        loadSrc(0, 6, 8'h01, 2);
        loadSrc(2, 6, 8'h21, 2);
        runSources("rot", 60, cycles);
        expQ = '{8'hA0, 8'h01, 8'h02, 8'hA2, 8'h21, 8'h22, 8'hA0, 8'h03, 8'h04,
                 8'hA2, 8'h23, 8'h24, 8'hA0, 8'h05, 8'h06, 8'hA2, 8'h25, 8'h26};
        checkStream("rot", base);
        checkOutput("rot_cycles", cycles, 24);
        checkOutput("rot_grant", grantId, 2'd2);

        // Reset after 2 of 5 bytes: packet aborted, arbitration restarts at 0.
        applyReset("midrst");
        base = outCnt;
        loadSrc(0, 5, 8'h51, 5);
        for (int i = 0; i < 4; i++) srcCycle();
        applyStimulus();
        rst = 1'b1;
        #1;
        checkOutput("midrst_outs", {sTready, mTvalid, mTdata, grantId, busy, lenErr}, 32'h0);
        step();
        step();
        checkOutput("midrst_hold", {sTvalid[0], sTready, mTvalid}, 6'b1_0000_0);
        checkOutput("midrst_count", outCnt - base, 3);
        clearSources();
        rst = 1'b0;
        base = outCnt;
        loadSrc(0, 1, 8'h61, 1);
        loadSrc(1, 1, 8'h71, 1);
        runSources("after", 20, cycles);
        expQ = '{8'hA0, 8'h61, 8'hA1, 8'h71};
        checkStream("after", base);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
